// File: rtl/alu4_tv_pkg.sv
// ---------------------------------------------------------------------------
// alu4_tv_pkg
//   Shared definitions for the ALU test-vector capture block:
//     TV_W        width of one packed test-vector record
//     tv_rec_t    record layout, MSB-first, same order as a .tv file line
//     cap_state_t capture controller states
//     DROP_MAX    saturation value of the drop counter
//     pack_tv()   builds a record from the ALU operands/result (and flags)
//
//   Optional feature macro: ALU4_TVCAP_FLAGS_EN
//     defined   -> TV_W = 19, record {a, b, op, result, c, n, z, v}
//     undefined -> TV_W = 15, record {a, b, op, result}
// ---------------------------------------------------------------------------
package alu4_tv_pkg;

`ifdef ALU4_TVCAP_FLAGS_EN
  localparam int TV_W = 19;
`else
  localparam int TV_W = 15;
`endif

  // Field order matters: it is the column order of a .tv line, so the
  // first declared field lands in the MSBs of tv_data.
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] result;
`ifdef ALU4_TVCAP_FLAGS_EN
    logic       c;
    logic       n;
    logic       z;
    logic       v;
`endif
  } tv_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

  localparam logic [7:0] DROP_MAX = 8'hFF;

`ifdef ALU4_TVCAP_FLAGS_EN
  // flags is {c, n, z, v}, so c ends up in tv_data[3] and v in tv_data[0].
  function automatic tv_rec_t pack_tv(input logic [3:0] a,
                                      input logic [3:0] b,
                                      input logic [2:0] op,
                                      input logic [3:0] result,
                                      input logic [3:0] flags);
    tv_rec_t rec;
    rec.a      = a;
    rec.b      = b;
    rec.op     = op;
    rec.result = result;
    rec.c      = flags[3];
    rec.n      = flags[2];
    rec.z      = flags[1];
    rec.v      = flags[0];
    return rec;
  endfunction
`else
  function automatic tv_rec_t pack_tv(input logic [3:0] a,
                                      input logic [3:0] b,
                                      input logic [2:0] op,
                                      input logic [3:0] result);
    tv_rec_t rec;
    rec.a      = a;
    rec.b      = b;
    rec.op     = op;
    rec.result = result;
    return rec;
  endfunction
`endif

endpackage

// File: rtl/alu4_tv_fifo.sv
// ---------------------------------------------------------------------------
// alu4_tv_fifo
//   Synchronous FIFO, DEPTH entries of W bits, single clock.
//
//   Ports
//     clk      clock, all state on rising edge
//     reset    synchronous active-high reset, empties the FIFO
//     push     write wr_data this cycle (ignored when full unless popping)
//     pop      remove head entry this cycle (ignored when empty)
//     wr_data  data to write
//     rd_data  head entry, forced to zero while empty
//     full     count == DEPTH
//     empty    count == 0
//     count    exact occupancy 0..DEPTH
//
//   DEPTH must be a power of two so the pointers wrap for free.
// ---------------------------------------------------------------------------
module alu4_tv_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is still legal when the head leaves in the
  // same cycle: the write lands in the slot being vacated.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);

  // Head is shown combinationally; it only changes when rd_ptr moves or
  // the FIFO goes from empty to non-empty, so it is stable under stall.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage array has no reset; stale contents are never visible because
  // rd_data is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/alu4_tv_capture.sv
// ---------------------------------------------------------------------------
// alu4_tv_capture
//   Captures ALU transactions into a FIFO as packed test-vector records
//   and drains them through a valid/ready stream.
//
//   Ports
//     clk        clock, all state on rising edge
//     reset      synchronous active-high reset, dominates everything
//     start      pulse: begin a capture session (from IDLE or DONE)
//     stop       pulse: end capture, begin draining (from CAPTURE)
//     cap_valid  ALU transaction present this cycle
//     a, b       ALU operands (4 bits each)
//     op         ALU opcode (3 bits)
//     result     ALU result (4 bits)
//     c,n,z,v    ALU flags, recorded only with ALU4_TVCAP_FLAGS_EN
//     tv_valid   record available on tv_data
//     tv_ready   sink accepts the record
//     tv_data    packed record {a, b, op, result[, c, n, z, v]}
//     rec_cnt    records accepted this session (wraps)
//     drop_cnt   records dropped on full FIFO this session (saturates)
//     busy       high in CAPTURE or DRAIN
//     done       high in DONE
//
//   Parameter DEPTH: FIFO entries, power of two in 4..256.
//   Optional feature macro: ALU4_TVCAP_FLAGS_EN (adds flags to the record).
// ---------------------------------------------------------------------------
module alu4_tv_capture
  import alu4_tv_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stop,
  input  logic            cap_valid,
  input  logic [3:0]      a,
  input  logic [3:0]      b,
  input  logic [2:0]      op,
  input  logic [3:0]      result,
  input  logic            c,
  input  logic            n,
  input  logic            z,
  input  logic            v,
  output logic            tv_valid,
  input  logic            tv_ready,
  output logic [TV_W-1:0] tv_data,
  output logic [15:0]     rec_cnt,
  output logic [7:0]      drop_cnt,
  output logic            busy,
  output logic            done
);

  cap_state_t              state_q;
  cap_state_t              state_d;
  logic                    session_clear;

  tv_rec_t                 rec_in;
  logic                    push_req;
  logic                    pop;
  logic                    accept;
  logic                    drop;

  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;

`ifdef ALU4_TVCAP_FLAGS_EN
  assign rec_in = pack_tv(a, b, op, result, {c, n, z, v});
`else
  // Flags stay on the port list so both builds share one pinout; they
  // simply do not reach the record here.
  logic flags_unused;
  assign flags_unused = ^{c, n, z, v};
  assign rec_in       = pack_tv(a, b, op, result);
`endif

  // Only CAPTURE records transactions. The cycle carrying stop is still a
  // CAPTURE cycle, so a transaction alongside stop is kept.
  assign push_req = (state_q == ST_CAPTURE) && cap_valid;
  assign pop      = tv_valid && tv_ready;
  assign accept   = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

  assign tv_valid = !fifo_empty;
  assign busy     = (state_q == ST_CAPTURE) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);

  alu4_tv_fifo #(
    .DEPTH (DEPTH),
    .W     (TV_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (accept),
    .pop     (pop),
    .wr_data (rec_in),
    .rd_data (tv_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. DRAIN looks at the registered occupancy, so DONE is
  // entered one cycle after the FIFO has actually gone empty. Starting a
  // new session also requests a counter clear in the same cycle.
  always_comb begin
    state_d       = state_q;
    session_clear = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_CAPTURE;
          session_clear = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (stop) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_count == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d       = ST_CAPTURE;
          session_clear = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Session counters. A clear can only happen in IDLE or DONE, where no
  // push is possible, so clear and increment never compete.
  always_ff @(posedge clk) begin
    if (reset) begin
      rec_cnt  <= '0;
      drop_cnt <= '0;
    end else if (session_clear) begin
      rec_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (accept) begin
        rec_cnt <= rec_cnt + 16'd1;
      end
      if (drop && (drop_cnt != DROP_MAX)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu4_tv_capture.sv
// ---------------------------------------------------------------------------
// tb_alu4_tv_capture
//   Directed self-checking bench for alu4_tv_capture (DEPTH = 16).
//   Flags are driven as c=1, n=0, z=0, v=1 throughout; with
//   ALU4_TVCAP_FLAGS_EN the expected records carry 4'b1001 in the LSBs.
// ---------------------------------------------------------------------------
module tb_alu4_tv_capture;

`ifdef ALU4_TVCAP_FLAGS_EN
  localparam int TB_W = 19;
  localparam logic [TB_W-1:0] S1_VEC = 19'b0011_0101_010_1000_1001;
`else
  localparam int TB_W = 15;
  localparam logic [TB_W-1:0] S1_VEC = 15'b0011_0101_010_1000;
`endif
  localparam int DEPTH = 16;

  logic            clk;
  logic            reset;
  logic            start;
  logic            stop;
  logic            cap_valid;
  logic [3:0]      a;
  logic [3:0]      b;
  logic [2:0]      op;
  logic [3:0]      result;
  logic            c;
  logic            n;
  logic            z;
  logic            v;
  logic            tv_valid;
  logic            tv_ready;
  logic [TB_W-1:0] tv_data;
  logic [15:0]     rec_cnt;
  logic [7:0]      drop_cnt;
  logic            busy;
  logic            done;

  int checks   = 0;
  int failures = 0;
  logic [TB_W-1:0] exp_q [$];

  alu4_tv_capture #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .cap_valid (cap_valid),
    .a         (a),
    .b         (b),
    .op        (op),
    .result    (result),
    .c         (c),
    .n         (n),
    .z         (z),
    .v         (v),
    .tv_valid  (tv_valid),
    .tv_ready  (tv_ready),
    .tv_data   (tv_data),
    .rec_cnt   (rec_cnt),
    .drop_cnt  (drop_cnt),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a stuck DUT can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog");
  end

  // Expected record: {a, b, op, result} plus the fixed flag pattern.
  function automatic logic [TB_W-1:0] makeRecord(input logic [3:0] ra,
                                                 input logic [3:0] rb,
                                                 input logic [2:0] rop,
                                                 input logic [3:0] rres);
`ifdef ALU4_TVCAP_FLAGS_EN
    return {ra, rb, rop, rres, 4'b1001};
`else
    return {ra, rb, rop, rres};
`endif
  endfunction

  function automatic logic [TB_W-1:0] idxRecord(input int i);
    return makeRecord(4'(i), 4'(15 - i), 3'(i), 4'(3 * i + 1));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after
  // the rising edge.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic cv,
                               input logic [3:0] ra, input logic [3:0] rb,
                               input logic [2:0] rop, input logic [3:0] rres,
                               input logic rdy);
    start     = st;
    stop      = sp;
    cap_valid = cv;
    a         = ra;
    b         = rb;
    op        = rop;
    result    = rres;
    tv_ready  = rdy;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0, 4'd0, 1'b0);
  endtask

  task automatic applyIndexed(input int i, input logic rdy);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'(i), 4'(15 - i), 3'(i), 4'(3 * i + 1), rdy);
  endtask

  // Drain the FIFO until done, comparing every popped record with exp_q.
  // With toggle set, tv_ready alternates 1,0,1,0... and each stalled head
  // must still be present and unchanged in the following cycle.
  task automatic drainRecords(input bit toggle, input string tag);
    logic [TB_W-1:0] held;
    bit              held_v;
    int              cycles;
    held   = '0;
    held_v = 1'b0;
    cycles = 0;
    while (!done && cycles < 400) begin
      tv_ready = toggle ? ((cycles % 2) == 0) : 1'b1;
      if (held_v) begin
        checkOutput({tag, "_hold_valid"}, tv_valid, 1);
        checkOutput({tag, "_hold_data"}, tv_data, held);
        held_v = 1'b0;
      end
      if (tv_valid) begin
        if (tv_ready) begin
          if (exp_q.size() == 0) begin
            checkOutput({tag, "_extra_pop"}, tv_valid, 0);
          end else begin
            checkOutput({tag, "_data"}, tv_data, exp_q.pop_front());
          end
        end else begin
          held   = tv_data;
          held_v = 1'b1;
        end
      end
      stepClock();
      cycles++;
    end
    tv_ready = 1'b0;
    checkOutput({tag, "_reached_done"}, done, 1);
    checkOutput({tag, "_records_left"}, exp_q.size(), 0);
  endtask

  initial begin
    c = 1'b1;
    n = 1'b0;
    z = 1'b0;
    v = 1'b1;
    reset = 1'b1;
    applyIdle();
    stepClock();
    stepClock();

    // Reset state
    checkOutput("rst_tv_valid", tv_valid, 0);
    checkOutput("rst_tv_data", tv_data, 0);
    checkOutput("rst_rec_cnt", rec_cnt, 0);
    checkOutput("rst_drop_cnt", drop_cnt, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    reset = 1'b0;

    // stop and cap_valid in IDLE are ignored
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd1, 4'd2, 3'd3, 4'd4, 1'b0);
    stepClock();
    checkOutput("idle_stop_busy", busy, 0);
    checkOutput("idle_stop_done", done, 0);
    checkOutput("idle_cap_rec_cnt", rec_cnt, 0);
    checkOutput("idle_cap_tv_valid", tv_valid, 0);

    // Session 1: three pushes, third one together with stop
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0, 4'd0, 1'b0);
    stepClock();
    checkOutput("s1_busy", busy, 1);
    checkOutput("s1_rec_cnt_start", rec_cnt, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd3, 4'd5, 3'b010, 4'd8, 1'b0);
    checkOutput("s1_latency_before", tv_valid, 0);
    stepClock();
    checkOutput("s1_latency_after", tv_valid, 1);
    checkOutput("s1_vector", tv_data, S1_VEC);
`ifdef ALU4_TVCAP_FLAGS_EN
    checkOutput("s1_flags", tv_data[3:0], 4'b1001);
`endif
    stepClock();
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd3, 4'd5, 3'b010, 4'd8, 1'b0);
    stepClock();
    for (int i = 0; i < 3; i++) exp_q.push_back(makeRecord(4'd3, 4'd5, 3'b010, 4'd8));
    checkOutput("s1_rec_cnt_stop", rec_cnt, 3);
    checkOutput("s1_drain_busy", busy, 1);
    applyIdle();
    drainRecords(1'b0, "s1_pop");
    checkOutput("s1_done_rec_cnt", rec_cnt, 3);
    checkOutput("s1_done_drop_cnt", drop_cnt, 0);
    checkOutput("s1_done_busy", busy, 0);

    // cap_valid and stop in DONE are ignored
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd7, 4'd7, 3'd7, 4'd7, 1'b0);
    stepClock();
    checkOutput("done_cap_rec_cnt", rec_cnt, 3);
    checkOutput("done_cap_tv_valid", tv_valid, 0);
    checkOutput("done_stop_done", done, 1);

    // Session 2: restart from DONE, overfill, push+pop while full, stalled drain
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0, 4'd0, 1'b0);
    stepClock();
    checkOutput("s2_clear_rec_cnt", rec_cnt, 0);
    checkOutput("s2_busy", busy, 1);
    for (int i = 0; i < 20; i++) begin
      applyIndexed(i, 1'b0);
      if (i < DEPTH) exp_q.push_back(idxRecord(i));
      stepClock();
    end
    applyIdle();
    checkOutput("s2_full_rec_cnt", rec_cnt, 16);
    checkOutput("s2_full_drop_cnt", drop_cnt, 4);
    checkOutput("s2_full_head", tv_data, idxRecord(0));

    applyIndexed(20, 1'b1);
    checkOutput("s2_pushpop_head", tv_data, exp_q.pop_front());
    exp_q.push_back(idxRecord(20));
    stepClock();
    checkOutput("s2_pushpop_rec_cnt", rec_cnt, 17);
    checkOutput("s2_pushpop_drop_cnt", drop_cnt, 4);
    checkOutput("s2_pushpop_head_next", tv_data, idxRecord(1));

    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 3'd0, 4'd0, 1'b0);
    stepClock();
    applyIdle();
    drainRecords(1'b1, "s2_pop");
    checkOutput("s2_done_rec_cnt", rec_cnt, 17);
    checkOutput("s2_done_drop_cnt", drop_cnt, 4);

    // Session 3: reset with five records buffered, all other inputs high
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0, 4'd0, 1'b0);
    stepClock();
    for (int i = 0; i < 5; i++) begin
      applyIndexed(i + 3, 1'b0);
      stepClock();
    end
    applyIdle();
    checkOutput("s3_rec_cnt", rec_cnt, 5);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd9, 4'd9, 3'd1, 4'd9, 1'b1);
    stepClock();
    checkOutput("s3_rst_tv_valid", tv_valid, 0);
    checkOutput("s3_rst_tv_data", tv_data, 0);
    checkOutput("s3_rst_rec_cnt", rec_cnt, 0);
    checkOutput("s3_rst_drop_cnt", drop_cnt, 0);
    checkOutput("s3_rst_busy", busy, 0);
    checkOutput("s3_rst_done", done, 0);
    reset = 1'b0;
    applyIdle();
    stepClock();
    checkOutput("s3_idle_busy", busy, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0, 4'd0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 3'd0, 4'd0, 1'b0);
    stepClock();
    checkOutput("s3_empty_tv_valid", tv_valid, 0);
    applyIdle();
    drainRecords(1'b0, "s3_empty");
    checkOutput("s3_empty_rec_cnt", rec_cnt, 0);

    // Session 4: drop counter saturation, start ignored during DRAIN
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0, 4'd0, 1'b0);
    stepClock();
    for (int i = 0; i < 300; i++) begin
      applyIndexed(i, 1'b0);
      stepClock();
    end
    applyIdle();
    checkOutput("s4_rec_cnt", rec_cnt, 16);
    checkOutput("s4_drop_sat", drop_cnt, 255);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 3'd0, 4'd0, 1'b0);
    stepClock();
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd2, 4'd2, 3'd2, 4'd2, 1'b0);
    stepClock();
    applyIdle();
    checkOutput("s4_drain_start_rec_cnt", rec_cnt, 16);
    checkOutput("s4_drain_start_drop_cnt", drop_cnt, 255);
    checkOutput("s4_drain_busy", busy, 1);
    checkOutput("s4_drain_done", done, 0);

    reset = 1'b1;
    stepClock();
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
